// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access controller.
//   state_e        : access FSM states (IDLE, WAIT, DONE)
//   *_W_DFLT       : default address, data and stall-counter widths
package mem_pkg;

    localparam int unsigned ADDR_W_DFLT = 32;
    localparam int unsigned DATA_W_DFLT = 32;
    localparam int unsigned CNT_W_DFLT  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; counts enabled cycles and sticks at all-ones.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count this cycle
//   cnt        : current count
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage data-memory access controller. Turns a pipeline load/store into a
// registered request/acknowledge transaction, stalling the pipeline until the
// memory completes, then releases the instruction for exactly one cycle.
//   CLK, ResetN            : clock, asynchronous active-low reset
//   MemReadM, MemWriteM    : M-stage load / store (both high = store)
//   RegWriteM              : M-stage register-write enable
//   ALUOutM, WriteDataM    : access address, store data
//   DReq, DWe, DAddr, DWData : registered request to data memory
//   DAck, DRData           : one-cycle completion and read data
//   StallM                 : freeze M and earlier stages (combinational)
//   RegWriteMG             : register write gated by stall / fault
//   ReadDataM              : last captured load data
//   AlignFault             : one-cycle pulse after a misaligned access
//   StallCnt               : saturating count of stalled cycles
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DFLT,
    parameter int unsigned DATA_W = DATA_W_DFLT,
    parameter int unsigned CNT_W  = CNT_W_DFLT
) (
    input  logic              CLK,
    input  logic              ResetN,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic              RegWriteM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic              DReq,
    output logic              DWe,
    output logic [ADDR_W-1:0] DAddr,
    output logic [DATA_W-1:0] DWData,
    input  logic              DAck,
    input  logic [DATA_W-1:0] DRData,
    output logic              StallM,
    output logic              RegWriteMG,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              AlignFault,
    output logic [CNT_W-1:0]  StallCnt
);

    state_e              state_q, state_d;
    logic                dreq_q, dreq_d;
    logic                dwe_q, dwe_d;
    logic [ADDR_W-1:0]   daddr_q, daddr_d;
    logic [DATA_W-1:0]   dwdata_q, dwdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                fault_q, fault_d;
    logic                stall_c;
    logic                misaligned_c;

    logic access_c;
    logic aligned_c;

    assign access_c  = MemReadM | MemWriteM;
    assign aligned_c = (ALUOutM[1:0] == 2'b00);

    // Next-state, request register and stall decode.
    always_comb begin
        state_d      = state_q;
        dreq_d       = dreq_q;
        dwe_d        = dwe_q;
        daddr_d      = daddr_q;
        dwdata_d     = dwdata_q;
        rdata_d      = rdata_q;
        fault_d      = 1'b0;
        stall_c      = 1'b0;
        misaligned_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_c) begin
                    if (aligned_c) begin
                        stall_c  = 1'b1;
                        dreq_d   = 1'b1;
                        dwe_d    = MemWriteM;
                        daddr_d  = ALUOutM;
                        dwdata_d = WriteDataM;
                        state_d  = WAIT;
                    end else begin
                        misaligned_c = 1'b1;
                        fault_d      = 1'b1;
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (DAck) begin
                    dreq_d = 1'b0;
                    dwe_d  = 1'b0;
                    // dwe_q still describes the finishing access here.
                    if (!dwe_q) begin
                        rdata_d = DRData;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state_q  <= IDLE;
            dreq_q   <= 1'b0;
            dwe_q    <= 1'b0;
            daddr_q  <= '0;
            dwdata_q <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dreq_q   <= dreq_d;
            dwe_q    <= dwe_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (CLK),
        .rst_n (ResetN),
        .en    (stall_c),
        .cnt   (StallCnt)
    );

    assign DReq       = dreq_q;
    assign DWe        = dwe_q;
    assign DAddr      = daddr_q;
    assign DWData     = dwdata_q;
    assign ReadDataM  = rdata_q;
    assign AlignFault = fault_q;
    assign StallM     = stall_c;
    // A faulting instruction must not write back even though it advances.
    assign RegWriteMG = RegWriteM & ~stall_c & ~misaligned_c;

endmodule
